// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared state encodings and default width for the counter set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/countdown_timer_if.sv
// ============================================================================
// Module      : countdown_timer_if
// Description : Control strobes and status outputs of the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface countdown_timer_if #(
    parameter int W = counter_pkg::CNT_W
) ();

    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;

    modport master (
        output load, load_val, start, stop, en, auto_reload,
        input  count, busy, tc, done
    );

    modport slave (
        input  load, load_val, start, stop, en, auto_reload,
        output count, busy, tc, done
    );

endinterface : countdown_timer_if

`default_nettype wire

// File: rtl/countdown_timer_dec_core.sv
// ============================================================================
// Module      : dec_core
// Description : Loadable W-bit down-counter saturating at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_core #(
    parameter int W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_load,
    input  wire logic [W-1:0] i_load_val,
    input  wire logic         i_dec_en,
    output logic      [W-1:0] o_count,
    output logic              o_is_one
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_is_one = (r_count == W'(1));

endmodule : dec_core

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// Module      : countdown_timer
// Description : Start/stop countdown timer with reload register, one-cycle
//               terminal-count pulse, sticky expiry flag and auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer
    import counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    countdown_timer_if.slave   bus
);

    state_t       r_state;
    logic [W-1:0] r_reload;
    logic         r_busy;
    logic         r_tc;
    logic         r_done;

    logic [W-1:0] w_count;
    logic         w_is_one;
    logic         w_is_zero;
    logic         w_in_run;
    logic         w_in_exp;
    logic         w_run_active;
    logic         w_terminal;
    logic         w_core_load;
    logic [W-1:0] w_core_val;
    logic         w_dec_en;

    assign w_is_zero    = (w_count == '0);
    assign w_in_run     = (r_state == ST_RUN);
    assign w_in_exp     = (r_state == ST_EXPIRED);
    assign w_run_active = w_in_run && !bus.load && !bus.stop && bus.en;
    assign w_terminal   = w_run_active && w_is_one;

    // The counter core is reloaded by an explicit load, a restart from
    // EXPIRED, or an auto-reload at terminal count; otherwise it decrements.
    assign w_core_load = bus.load
                      || (w_in_exp && bus.start)
                      || (w_terminal && bus.auto_reload);
    assign w_core_val  = bus.load ? bus.load_val : r_reload;
    assign w_dec_en    = w_run_active;

    dec_core #(
        .W (W)
    ) u_dec_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_core_load),
        .i_load_val (w_core_val),
        .i_dec_en   (w_dec_en),
        .o_count    (w_count),
        .o_is_one   (w_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_tc     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.load) begin
                r_reload <= bus.load_val;
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (w_is_zero) begin
                                r_state <= ST_EXPIRED;
                                r_tc    <= 1'b1;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bus.stop) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_terminal) begin
                            r_tc <= 1'b1;
                            if (!bus.auto_reload) begin
                                r_state <= ST_EXPIRED;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        if (bus.start) begin
                            if (r_reload != '0) begin
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end else begin
                                // Zero reload re-expires on the spot.
                                r_tc   <= 1'b1;
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count = w_count;
    assign bus.busy  = r_busy;
    assign bus.tc    = r_tc;
    assign bus.done  = r_done;

endmodule : countdown_timer

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter/countdown timer; the decrementing counterpart to the team's enable-gated up-counter.
- Software or upstream logic loads a reload value, starts it, and gates each decrement with an enable.
- Emits a one-cycle terminal-count pulse at zero, with optional auto-reload for periodic ticks.
- Sits beside the up-counter in the Level 1 counter set; used as a timeout/prescaler primitive.

Parameters:
W, 4, counter and reload width in bits (legal 2..16)

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous active-high reset
load  input  1  one-cycle strobe: capture load_val into reload register and count
load_val  input  W  value captured on load
start  input  1  one-cycle strobe: begin countdown
stop  input  1  one-cycle strobe: abort countdown, count frozen
en  input  1  decrement enable; count moves only when high in RUN
auto_reload  input  1  1 = reload and continue at terminal count; 0 = stop at zero
count  output  W  current counter value, registered
busy  output  1  high while state is RUN
tc  output  1  terminal-count pulse, exactly one cycle, registered
done  output  1  sticky expiry flag, high in EXPIRED

Behaviour:
- All outputs registered; all state changes on the rising edge of clk.
- Reset: on clk edge with rst=1, count=0, reload register=0, state=IDLE, busy=0, tc=0, done=0.
- Reset mid-RUN aborts immediately; no tc is generated.
- Priority in one cycle: rst > load > stop > start > en.
- States: IDLE, RUN, EXPIRED (2-bit encoding).
- load (any state):
  - reload register and count <= load_val; state <= IDLE; done <= 0; tc <= 0.
  - start/stop/en in the same cycle are ignored.
- start in IDLE:
  - count != 0: state <= RUN. Count is unchanged that cycle; the first decrement occurs on the next enabled cycle.
  - count == 0: state <= EXPIRED; tc <= 1 for one cycle; done <= 1.
- start in EXPIRED:
  - count <= reload register; done <= 0.
  - reload register != 0: state <= RUN.
  - reload register == 0: re-expire, same as the IDLE/count==0 case (tc pulse, done set).
- start in RUN: ignored.
- stop in RUN: state <= IDLE; count holds; no tc. stop is ignored in IDLE and EXPIRED.
- RUN with en=0: count holds, busy stays 1.
- RUN with en=1 and count > 1: count <= count - 1.
- RUN with en=1 and count == 1 (terminal):
  - tc <= 1 next cycle.
  - auto_reload=0: count <= 0; state <= EXPIRED; done <= 1.
  - auto_reload=1: count <= reload register; stay in RUN; done stays 0.
  - With reload register == 1 and auto_reload=1, tc pulses on every enabled cycle.
- No wrap-around: count never decrements below 0. EXPIRED holds 0 regardless of en.
- auto_reload is sampled only at the terminal decrement. Changing it mid-count has no other effect.
- tc is 0 in every cycle not listed above; it never stays high for two cycles except in the back-to-back reload-1 case.
- Latency: load_val = N, start, en held high → tc seen N cycles after the cycle following start.

Decomposition:
- Shared package (counter_pkg): state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_EXPIRED=2'b10, plus the default width constant CNT_W=4.
- One natural sub-module, dec_core: a W-bit register that takes load/load_val and dec_en and outputs count and is_one (count == 1).
  - It decrements with saturation at 0.
  - countdown_timer wraps it with the FSM, reload register, and tc/done logic.

Test Plan:
- Basic one-shot: rst; load_val=4 load; start; en=1 → count 4,3,2,1,0; tc high one cycle as count shows 0; done=1, busy=0; count stays 0 for 5 more cycles.
- Enable gating: load 3, start, en toggling 1,0,0,1,1 → count 3,2,2,2,1,0; tc exactly once; busy high throughout RUN.
- Auto-reload: auto_reload=1, load 2, start, en=1 for 8 cycles → count 2,1,2,1,…; tc on every second cycle, 4 pulses; done stays 0.
- Boundaries:
  - load 0 then start → EXPIRED next cycle with one tc pulse and done=1.
  - W=4, load 15 → 15 enabled cycles to tc, no wrap to 15 after 0.
- Priority/simultaneous:
  - load=1 with start=1, load_val=5 → IDLE, count 5, busy 0.
  - In RUN at count 1, stop=1 with en=1 → IDLE, count 1, no tc.
  - start while RUN → no effect.
- Reset mid-operation: load 9, start, run 3 enabled cycles, assert rst one cycle → next cycle count 0, state IDLE, tc=0, done=0, reload register 0 (a subsequent start expires immediately).
